// File: rtl/alu_issue_controller.sv
// Round-robin arbiter and sequencer in front of a shared combinational ALU.
// Registers the granted op, holds it for the opcode's latency, then presents a tagged response.
module alu_issue_controller #(
   parameter int WIDTH      = 16,
   parameter int MUL_CYCLES = 2,
   parameter int DIV_CYCLES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [4:0]       req0_opcode,
   input  logic [WIDTH-1:0] req0_x,
   input  logic [WIDTH-1:0] req0_y,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [4:0]       req1_opcode,
   input  logic [WIDTH-1:0] req1_x,
   input  logic [WIDTH-1:0] req1_y,
   output logic [4:0]       alu_opcode,
   output logic [WIDTH-1:0] alu_x,
   output logic [WIDTH-1:0] alu_y,
   input  logic [WIDTH-1:0] alu_r,
   input  logic [4:0]       alu_flags,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_r,
   output logic [4:0]       rsp_flags,
   output logic             busy
);

   localparam int MAX_LAT = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
   localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t           state, state_next;
   logic             last_grant;
   logic             grant_valid;
   logic             grant_id;
   logic [CNT_W-1:0] cnt;
   logic [4:0]       sel_opcode;
   logic [WIDTH-1:0] sel_x;
   logic [WIDTH-1:0] sel_y;

   function automatic logic is_mul(input logic [4:0] op);
      return (op == 5'b00011) || (op == 5'b01111);
   endfunction

   function automatic logic is_divmod(input logic [4:0] op);
      return (op == 5'b00100) || (op == 5'b00101);
   endfunction

   // Counter load is latency minus one so EXEC lasts exactly LAT cycles.
   function automatic logic [CNT_W-1:0] lat_minus_one(input logic [4:0] op);
      if (is_divmod(op))
         return CNT_W'(DIV_CYCLES - 1);
      else if (is_mul(op))
         return CNT_W'(MUL_CYCLES - 1);
      else
         return '0;
   endfunction

   // On a tie the requester that did not win last time is granted.
   always_comb begin
      grant_valid = (state == IDLE) && (req0_valid || req1_valid);
      if (req0_valid && req1_valid)
         grant_id = ~last_grant;
      else
         grant_id = req1_valid;
      req0_ready = grant_valid && !grant_id;
      req1_ready = grant_valid && grant_id;
      sel_opcode = grant_id ? req1_opcode : req0_opcode;
      sel_x      = grant_id ? req1_x : req0_x;
      sel_y      = grant_id ? req1_y : req0_y;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (grant_valid) state_next = EXEC;
         EXEC:    if (cnt == '0) state_next = RESP;
         RESP:    if (rsp_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_next;
   end

   // The div_invalid flag is only meaningful for divide/modulo results.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_opcode <= '0;
         alu_x      <= '0;
         alu_y      <= '0;
         last_grant <= 1'b1;
         cnt        <= '0;
         rsp_id     <= 1'b0;
         rsp_r      <= '0;
         rsp_flags  <= '0;
      end else begin
         if (grant_valid) begin
            alu_opcode <= sel_opcode;
            alu_x      <= sel_x;
            alu_y      <= sel_y;
            rsp_id     <= grant_id;
            last_grant <= grant_id;
            cnt        <= lat_minus_one(sel_opcode);
         end else if (state == EXEC) begin
            if (cnt != '0) begin
               cnt <= cnt - CNT_W'(1);
            end else begin
               rsp_r     <= alu_r;
               rsp_flags <= {alu_flags[4] & is_divmod(alu_opcode), alu_flags[3:0]};
            end
         end
      end
   end

   assign rsp_valid = (state == RESP);
   assign busy      = (state != IDLE);

endmodule

// File: tb/tb_alu_issue_controller.sv
// Testbench for alu_issue_controller: directed and randomized transactions checked against
// a transaction-level model of grants, latencies and results; a simple ALU model drives alu_r/flags.
module tb_alu_issue_controller;

   localparam int WIDTH      = 16;
   localparam int MUL_CYCLES = 2;
   localparam int DIV_CYCLES = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             req0_valid, req0_ready, req1_valid, req1_ready;
   logic [4:0]       req0_opcode, req1_opcode, alu_opcode, alu_flags, rsp_flags;
   logic [WIDTH-1:0] req0_x, req0_y, req1_x, req1_y, alu_x, alu_y, alu_r, rsp_r;
   logic             rsp_valid, rsp_ready, rsp_id, busy;
   logic             inject_div_invalid;
   logic             model_last_grant;
   int               test_count = 0;
   int               fail_count = 0;

   alu_issue_controller #(
      .WIDTH(WIDTH), .MUL_CYCLES(MUL_CYCLES), .DIV_CYCLES(DIV_CYCLES)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
      .req0_x(req0_x), .req0_y(req0_y),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
      .req1_x(req1_x), .req1_y(req1_y),
      .alu_opcode(alu_opcode), .alu_x(alu_x), .alu_y(alu_y),
      .alu_r(alu_r), .alu_flags(alu_flags),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_r(rsp_r), .rsp_flags(rsp_flags), .busy(busy)
   );

   always #5 clk = ~clk;

   // Returns {div_invalid, overflow, negative, zero, cout, result}.
   function automatic logic [20:0] alu_fn(input logic [4:0] op, input logic [15:0] x,
                                          input logic [15:0] y, input logic inj);
      logic [16:0] wide;
      logic [31:0] prod;
      logic [15:0] r;
      logic        cout, ovf, dinv;
      wide = '0; prod = '0; r = '0; cout = 1'b0; ovf = 1'b0;
      case (op)
         5'd0: begin
            wide = {1'b0, x} + {1'b0, y};
            r = wide[15:0]; cout = wide[16];
            ovf = (x[15] == y[15]) && (r[15] != x[15]);
         end
         5'd1: begin
            wide = {1'b0, x} - {1'b0, y};
            r = wide[15:0]; cout = wide[16];
            ovf = (x[15] != y[15]) && (r[15] != x[15]);
         end
         5'd3, 5'd15: begin
            prod = {16'b0, x} * {16'b0, y};
            r = prod[15:0]; ovf = (prod[31:16] != 16'b0);
         end
         5'd4:    r = (y == 16'd0) ? 16'hFFFF : x / y;
         5'd5:    r = (y == 16'd0) ? x : x % y;
         default: r = x ^ y;
      endcase
      dinv = inj || (((op == 5'd4) || (op == 5'd5)) && (y == 16'd0));
      return {dinv, ovf, r[15], (r == 16'd0), cout, r};
   endfunction

   function automatic int lat_of(input logic [4:0] op);
      if (op == 5'd4 || op == 5'd5) return DIV_CYCLES;
      if (op == 5'd3 || op == 5'd15) return MUL_CYCLES;
      return 1;
   endfunction

   always_comb {alu_flags, alu_r} = alu_fn(alu_opcode, alu_x, alu_y, inject_div_invalid);

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      test_count++;
      assert (observed === expected)
      else begin
         fail_count++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // One full transaction: offer requests, check the grant, EXEC timing, response and handshake.
   task automatic applyStimulus(input logic v0, input logic v1,
                                input logic [4:0] o0, input logic [15:0] x0, input logic [15:0] y0,
                                input logic [4:0] o1, input logic [15:0] x1, input logic [15:0] y1,
                                input logic inj, input int stall);
      logic        g;
      logic [4:0]  eo;
      logic [15:0] ex, ey;
      logic [20:0] res;
      logic [4:0]  ef;
      int          lat;
      inject_div_invalid = inj;
      req0_valid = v0; req0_opcode = o0; req0_x = x0; req0_y = y0;
      req1_valid = v1; req1_opcode = o1; req1_x = x1; req1_y = y1;
      rsp_ready = (stall == 0);
      g   = (v0 && v1) ? ~model_last_grant : v1;
      eo  = g ? o1 : o0;
      ex  = g ? x1 : x0;
      ey  = g ? y1 : y0;
      res = alu_fn(eo, ex, ey, inj);
      ef  = res[20:16];
      if (!(eo == 5'd4 || eo == 5'd5)) ef[4] = 1'b0;
      lat = lat_of(eo);
      #1;
      checkOutput("req0_ready_grant", req0_ready, !g);
      checkOutput("req1_ready_grant", req1_ready, g);
      model_last_grant = g;
      @(negedge clk);
      if (g) req1_valid = 1'b0; else req0_valid = 1'b0;
      for (int k = 0; k < lat; k++) begin
         #1;
         checkOutput("exec_rsp_valid", rsp_valid, 0);
         checkOutput("exec_busy", busy, 1);
         checkOutput("exec_no_ready", req0_ready | req1_ready, 0);
         checkOutput("exec_alu_opcode", alu_opcode, eo);
         checkOutput("exec_alu_x", alu_x, ex);
         checkOutput("exec_alu_y", alu_y, ey);
         @(negedge clk);
      end
      for (int s = 0; s < stall; s++) begin
         #1;
         checkOutput("stall_rsp_valid", rsp_valid, 1);
         checkOutput("stall_rsp_id", rsp_id, g);
         checkOutput("stall_rsp_r", rsp_r, res[15:0]);
         checkOutput("stall_rsp_flags", rsp_flags, ef);
         checkOutput("stall_busy", busy, 1);
         checkOutput("stall_no_ready", req0_ready | req1_ready, 0);
         checkOutput("stall_alu_x", alu_x, ex);
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      #1;
      checkOutput("rsp_valid", rsp_valid, 1);
      checkOutput("rsp_id", rsp_id, g);
      checkOutput("rsp_r", rsp_r, res[15:0]);
      checkOutput("rsp_flags", rsp_flags, ef);
      checkOutput("rsp_no_ready", req0_ready | req1_ready, 0);
      @(negedge clk);
      #1;
      checkOutput("post_rsp_valid", rsp_valid, 0);
      checkOutput("post_busy", busy, 0);
   endtask

   initial begin
      logic [4:0]  ops [9];
      logic [4:0]  ra, rb;
      logic        rv0, rv1;
      ops = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd15, 5'd7, 5'd31};
      rst_n = 1'b0;
      req0_valid = 1'b0; req0_opcode = '0; req0_x = '0; req0_y = '0;
      req1_valid = 1'b0; req1_opcode = '0; req1_x = '0; req1_y = '0;
      rsp_ready = 1'b0; inject_div_invalid = 1'b0; model_last_grant = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      checkOutput("reset_alu_opcode", alu_opcode, 0);
      checkOutput("reset_alu_x", alu_x, 0);
      checkOutput("reset_alu_y", alu_y, 0);
      checkOutput("reset_rsp_valid", rsp_valid, 0);
      checkOutput("reset_rsp_id", rsp_id, 0);
      checkOutput("reset_rsp_r", rsp_r, 0);
      checkOutput("reset_rsp_flags", rsp_flags, 0);
      checkOutput("reset_busy", busy, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      applyStimulus(1, 0, 5'd0, 16'd3, 16'd4, 5'd0, 16'd0, 16'd0, 0, 0);

      for (int i = 0; i < 6; i++)
         applyStimulus(1, 1, ops[$urandom_range(0, 8)], 16'($urandom), 16'($urandom),
                       ops[$urandom_range(0, 8)], 16'($urandom), 16'($urandom), 0, 0);

      applyStimulus(0, 1, 5'd0, 16'd0, 16'd0, 5'd4, 16'd100, 16'd0, 0, 0);
      applyStimulus(1, 0, 5'd3, 16'd300, 16'd500, 5'd0, 16'd0, 16'd0, 0, 5);

      // Reset during EXEC of a multiply from req0, then a tie must go to req0.
      req1_valid = 1'b0;
      req0_valid = 1'b1; req0_opcode = 5'd3; req0_x = 16'd7; req0_y = 16'd9;
      rsp_ready = 1'b1;
      #1;
      checkOutput("mul_req0_ready", req0_ready, 1);
      @(negedge clk);
      req0_valid = 1'b0;
      #1;
      checkOutput("mul_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      checkOutput("midreset_busy", busy, 0);
      checkOutput("midreset_rsp_valid", rsp_valid, 0);
      checkOutput("midreset_alu_opcode", alu_opcode, 0);
      checkOutput("midreset_alu_x", alu_x, 0);
      checkOutput("midreset_rsp_r", rsp_r, 0);
      model_last_grant = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         checkOutput("after_reset_no_rsp", rsp_valid, 0);
         @(negedge clk);
      end
      applyStimulus(1, 1, 5'd1, 16'd10, 16'd20, 5'd0, 16'd1, 16'd2, 0, 0);

      applyStimulus(1, 0, 5'd0, 16'd5, 16'd0, 5'd0, 16'd0, 16'd0, 1, 1);

      for (int i = 0; i < 20; i++) begin
         rv0 = 1'($urandom_range(0, 1));
         rv1 = rv0 ? 1'($urandom_range(0, 1)) : 1'b1;
         ra  = ops[$urandom_range(0, 8)];
         rb  = ops[$urandom_range(0, 8)];
         applyStimulus(rv0, rv1, ra, 16'($urandom), 16'($urandom_range(0, 3)),
                       rb, 16'($urandom), 16'($urandom_range(0, 3)),
                       1'($urandom_range(0, 1)), $urandom_range(0, 3));
      end

      $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
      $finish;
   end

endmodule
